// File: rtl/array_arith_pl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : array_arith_pl_pkg
//  Description : Shared widths, latency and the lane-slice helper for the
//                lane-array multiply and accumulate units.
//  Revision    : 1.0  initial release
// ============================================================================
package array_arith_pl_pkg;

    localparam int CACHE_WIDTH = 512;
    localparam int DATA_WIDTH  = 32;
    localparam int DATA_SIZE   = CACHE_WIDTH / DATA_WIDTH;   // lanes per line
    localparam int MUL_LATENCY = 1 + $clog2(DATA_SIZE);      // product stage + tree

    // Lane idx of a cache line occupies bits [32*idx+31 : 32*idx]
    function automatic logic [DATA_WIDTH-1:0] lane_of(
        input logic [CACHE_WIDTH-1:0] line,
        input int unsigned            idx
    );
        return line[idx*DATA_WIDTH +: DATA_WIDTH];
    endfunction

endpackage : array_arith_pl_pkg
`default_nettype wire

// File: rtl/array_arith_pl_if.sv
`default_nettype none
// ============================================================================
//  Module      : array_mul_if / array_accu_if
//  Description : Operand/result bundles of the dot-product unit and of the
//                lane-wise accumulator. master = datapath, slave = unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface array_mul_if;
    import array_arith_pl_pkg::*;

    logic                   enable;
    logic [CACHE_WIDTH-1:0] array1;
    logic [CACHE_WIDTH-1:0] array2;
    logic [DATA_WIDTH-1:0]  res;
    logic                   ready;

    modport master (output enable, array1, array2, input  res, ready);
    modport slave  (input  enable, array1, array2, output res, ready);
endinterface : array_mul_if

interface array_accu_if;
    import array_arith_pl_pkg::*;

    logic                   inc;
    logic                   out;
    logic [CACHE_WIDTH-1:0] array;
    logic [CACHE_WIDTH-1:0] res;
    logic                   ready;

    modport master (output inc, out, array, input  res, ready);
    modport slave  (input  inc, out, array, output res, ready);
endinterface : array_accu_if
`default_nettype wire

// File: rtl/array_arith_pl_accu.sv
`default_nettype none
// ============================================================================
//  Module      : array_accu_pl
//  Description : Lane-wise group accumulator. inc adds the incoming line,
//                out emits the group total (including a same-cycle inc) and
//                restarts the sum from zero.
//  Revision    : 1.0  initial release
// ============================================================================
module array_accu_pl
    import array_arith_pl_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    array_accu_if.slave bus
);

    logic [DATA_SIZE-1:0][DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_SIZE-1:0][DATA_WIDTH-1:0] res_q, res_d;
    logic [DATA_SIZE-1:0][DATA_WIDTH-1:0] add_w;
    logic                                 ready_q, ready_d;

    // Per-lane add (no inter-lane carry) and group open/close decision
    always_comb begin
        add_w   = '0;
        sum_d   = sum_q;
        res_d   = res_q;
        ready_d = 1'b0;
        for (int i = 0; i < DATA_SIZE; i++) begin
            add_w[i] = sum_q[i] + (bus.inc ? lane_of(bus.array, i) : '0);
        end
        if (bus.out) begin
            res_d   = add_w;
            ready_d = 1'b1;
            sum_d   = '0;
        end else if (bus.inc) begin
            sum_d = add_w;
        end
    end

    // Running sum, result and strobe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            res_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            res_q   <= res_d;
            ready_q <= ready_d;
        end
    end

    assign bus.res   = res_q;
    assign bus.ready = ready_q;

endmodule : array_accu_pl
`default_nettype wire

// File: rtl/array_arith_pl_adder_tree.sv
`default_nettype none
// ============================================================================
//  Module      : adder_tree_pl
//  Description : Registered binary reduction tree of 2**LEVELS operands with
//                a valid bit travelling alongside. Each level only loads when
//                its incoming data is valid, so the output holds between
//                results.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_tree_pl #(
    parameter int DATA_WIDTH = 32,
    parameter int LEVELS     = 4
) (
    input  wire logic                                      clk,
    input  wire logic                                      rst,
    input  wire logic                                      valid_i,
    input  wire logic [(1<<LEVELS)-1:0][DATA_WIDTH-1:0]    data_i,
    output logic                                           valid_o,
    output logic [DATA_WIDTH-1:0]                          sum_o
);

    localparam int NUM_IN = 1 << LEVELS;

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int NODES = NUM_IN >> (l + 1);

        logic [2*NODES-1:0][DATA_WIDTH-1:0] in_w;
        logic                               in_valid_w;
        logic [NODES-1:0][DATA_WIDTH-1:0]   sum_q;
        logic                               valid_q;

        if (l == 0) begin : g_first
            assign in_w       = data_i;
            assign in_valid_w = valid_i;
        end else begin : g_inner
            assign in_w       = g_level[l-1].sum_q;
            assign in_valid_w = g_level[l-1].valid_q;
        end

        // Pairwise add of the previous level; load only on valid data
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid_w;
                if (in_valid_w) begin
                    for (int j = 0; j < NODES; j++) begin
                        sum_q[j] <= in_w[2*j] + in_w[2*j+1];
                    end
                end
            end
        end
    end

    assign sum_o   = g_level[LEVELS-1].sum_q[0];
    assign valid_o = g_level[LEVELS-1].valid_q;

endmodule : adder_tree_pl
`default_nettype wire

// File: rtl/array_arith_pl_mul.sv
`default_nettype none
// ============================================================================
//  Module      : array_mul_pl
//  Description : Pipelined dot product of two lines of 32-bit lanes, modulo
//                2**32. One product stage followed by a registered adder
//                tree; one operation per cycle, no back-pressure.
//  Revision    : 1.0  initial release
// ============================================================================
module array_mul_pl
    import array_arith_pl_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst,
    array_mul_if.slave bus
);

    localparam int TREE_LEVELS = MUL_LATENCY - 1;

    logic [DATA_SIZE-1:0][DATA_WIDTH-1:0] prod_d;
    logic [DATA_SIZE-1:0][DATA_WIDTH-1:0] prod_q;
    logic                                 valid_q;

    // Lane products, truncated to the lane width
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < DATA_SIZE; i++) begin
            prod_d[i] = lane_of(bus.array1, i) * lane_of(bus.array2, i);
        end
    end

    // Product stage register with its valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.enable;
            if (bus.enable) begin
                prod_q <= prod_d;
            end
        end
    end

    adder_tree_pl #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEVELS     (TREE_LEVELS)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_q),
        .data_i  (prod_q),
        .valid_o (bus.ready),
        .sum_o   (bus.res)
    );

endmodule : array_mul_pl
`default_nettype wire

// File: rtl/array_arith_pl.sv
`default_nettype none
// ============================================================================
//  Module      : array_arith_pl
//  Description : Lane-array arithmetic pair of the matrix-multiply datapath:
//                a pipelined dot-product unit and a group accumulator on a
//                common clock and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module array_arith_pl (
    input  wire logic   clk,
    input  wire logic   rst,
    array_mul_if.slave  mul_bus,
    array_accu_if.slave accu_bus
);

    array_mul_pl u_mul (
        .clk (clk),
        .rst (rst),
        .bus (mul_bus)
    );

    array_accu_pl u_accu (
        .clk (clk),
        .rst (rst),
        .bus (accu_bus)
    );

endmodule : array_arith_pl
`default_nettype wire

// File: tb/tb_array_arith_pl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_arith_pl
//  Description : Directed self-checking bench for the dot-product unit and
//                the group accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_array_arith_pl;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    array_mul_if  mul_bus ();
    array_accu_if accu_bus ();

    array_arith_pl dut (
        .clk      (clk),
        .rst      (rst),
        .mul_bus  (mul_bus),
        .accu_bus (accu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance past one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] fill(input logic [31:0] v);
        return {16{v}};
    endfunction

    initial begin
        logic [511:0] a1;
        logic [511:0] exp_v;
        int           hits;

        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        mul_bus.enable  = 1'b0;
        mul_bus.array1  = '0;
        mul_bus.array2  = '0;
        accu_bus.inc    = 1'b0;
        accu_bus.out    = 1'b0;
        accu_bus.array  = '0;
        tick();
        tick();
        check("rst_mul_ready",  {511'd0, mul_bus.ready},  512'd0);
        check("rst_mul_res",    {480'd0, mul_bus.res},    512'd0);
        check("rst_accu_ready", {511'd0, accu_bus.ready}, 512'd0);
        check("rst_accu_res",   accu_bus.res,             512'd0);
        rst = 1'b0;

        // Single dot product: lanes 1..16 times 2 = 272, ready on 5th edge
        for (int i = 0; i < 16; i++) a1[i*32 +: 32] = 32'(i + 1);
        for (int n = 1; n <= 8; n++) begin
            mul_bus.enable = (n == 1);
            mul_bus.array1 = a1;
            mul_bus.array2 = fill(32'd2);
            tick();
            check("mul1_ready", {511'd0, mul_bus.ready}, {511'd0, (n == 5)});
            if (n == 5) check("mul1_res", {480'd0, mul_bus.res}, 512'd272);
        end

        // Streaming: all-k times all-1 for k=1..4 -> 16,32,48,64
        for (int n = 1; n <= 10; n++) begin
            mul_bus.enable = (n <= 4);
            mul_bus.array1 = fill(32'(n));
            mul_bus.array2 = fill(32'd1);
            tick();
            check("mul_stream_ready", {511'd0, mul_bus.ready}, {511'd0, (n >= 5 && n <= 8)});
            if (n >= 5 && n <= 8)
                check("mul_stream_res", {480'd0, mul_bus.res}, 512'(16 * (n - 4)));
        end

        // Gap: enables on edges 1 and 3 -> ready on 5 and 7; res holds on 6
        for (int i = 0; i < 16; i++) a1[i*32 +: 32] = 32'(i);
        for (int n = 1; n <= 8; n++) begin
            mul_bus.enable = (n == 1 || n == 3);
            mul_bus.array1 = (n == 1) ? fill(32'd3) : a1;
            mul_bus.array2 = fill(32'd1);
            tick();
            check("mul_gap_ready", {511'd0, mul_bus.ready}, {511'd0, (n == 5 || n == 7)});
            if (n == 5 || n == 6) check("mul_gap_res48", {480'd0, mul_bus.res}, 512'd48);
            if (n == 7)           check("mul_gap_res120", {480'd0, mul_bus.res}, 512'd120);
        end

        // Wrap-around: 0xFFFFFFFF * 2 in lane 7 -> 0xFFFFFFFE
        a1 = '0;
        a1[7*32 +: 32] = 32'hFFFF_FFFF;
        exp_v = '0;
        exp_v[7*32 +: 32] = 32'd2;
        for (int n = 1; n <= 6; n++) begin
            mul_bus.enable = (n == 1);
            mul_bus.array1 = a1;
            mul_bus.array2 = exp_v;
            tick();
            if (n == 5) begin
                check("mul_wrap_ready", {511'd0, mul_bus.ready}, 512'd1);
                check("mul_wrap_res", {480'd0, mul_bus.res}, {480'd0, 32'hFFFF_FFFE});
            end
        end

        // Reset two cycles after an enable: no ready may ever follow
        hits = 0;
        for (int n = 1; n <= 10; n++) begin
            mul_bus.enable = (n == 1);
            mul_bus.array1 = fill(32'd1);
            mul_bus.array2 = fill(32'd1);
            rst = (n == 3);
            tick();
            if (mul_bus.ready) hits++;
        end
        rst = 1'b0;
        check("mul_rst_no_ready", 512'(hits), 512'd0);
        check("mul_rst_res", {480'd0, mul_bus.res}, 512'd0);

        // Accumulate 5+6+7, out with the third -> 18; then 1 alone -> 1
        accu_bus.inc = 1'b1; accu_bus.out = 1'b0; accu_bus.array = fill(32'd5);
        tick();
        check("acc_g1_ready_a", {511'd0, accu_bus.ready}, 512'd0);
        accu_bus.array = fill(32'd6);
        tick();
        check("acc_g1_ready_b", {511'd0, accu_bus.ready}, 512'd0);
        accu_bus.out = 1'b1; accu_bus.array = fill(32'd7);
        tick();
        check("acc_g1_ready", {511'd0, accu_bus.ready}, 512'd1);
        check("acc_g1_res", accu_bus.res, fill(32'd18));
        accu_bus.array = fill(32'd1);
        tick();
        check("acc_g2_ready", {511'd0, accu_bus.ready}, 512'd1);
        check("acc_g2_res", accu_bus.res, fill(32'd1));
        accu_bus.inc = 1'b0; accu_bus.out = 1'b0;
        tick();
        check("acc_idle_ready", {511'd0, accu_bus.ready}, 512'd0);
        check("acc_idle_hold", accu_bus.res, fill(32'd1));

        // inc 9, idle cycle, then out alone -> 9
        accu_bus.inc = 1'b1; accu_bus.array = fill(32'd9);
        tick();
        accu_bus.inc = 1'b0;
        tick();
        accu_bus.out = 1'b1;
        tick();
        check("acc_out_only_ready", {511'd0, accu_bus.ready}, 512'd1);
        check("acc_out_only_res", accu_bus.res, fill(32'd9));

        // Lane wrap: lane3 0xFFFFFFFF+1 -> 0, neighbours 5+1 and 7+1
        exp_v = '0;
        exp_v[2*32 +: 32] = 32'd5;
        exp_v[3*32 +: 32] = 32'hFFFF_FFFF;
        exp_v[4*32 +: 32] = 32'd7;
        accu_bus.inc = 1'b1; accu_bus.out = 1'b0; accu_bus.array = exp_v;
        tick();
        exp_v = '0;
        exp_v[2*32 +: 32] = 32'd1;
        exp_v[3*32 +: 32] = 32'd1;
        exp_v[4*32 +: 32] = 32'd1;
        accu_bus.out = 1'b1; accu_bus.array = exp_v;
        tick();
        exp_v = '0;
        exp_v[2*32 +: 32] = 32'd6;
        exp_v[4*32 +: 32] = 32'd8;
        check("acc_wrap_res", accu_bus.res, exp_v);

        // inc 4, then reset together with inc/out, then out alone -> 0
        accu_bus.inc = 1'b1; accu_bus.out = 1'b0; accu_bus.array = fill(32'd4);
        tick();
        rst = 1'b1; accu_bus.out = 1'b1;
        tick();
        check("acc_rst_ready", {511'd0, accu_bus.ready}, 512'd0);
        check("acc_rst_res", accu_bus.res, 512'd0);
        rst = 1'b0; accu_bus.inc = 1'b0; accu_bus.out = 1'b1;
        tick();
        check("acc_post_rst_ready", {511'd0, accu_bus.ready}, 512'd1);
        check("acc_post_rst_res", accu_bus.res, 512'd0);
        accu_bus.out = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_array_arith_pl
`default_nettype wire
